// File: rtl/rv_pkg.sv
// Shared definitions for the fetch/decode boundary: NOP bubble encoding and
// the layout of one buffered instruction-queue entry.
package rv_pkg;

  localparam int XLEN = 32;
  localparam logic [XLEN-1:0] NOP_INSTR = 32'h0000_0013;

  // Entry layout, MSB to LSB: {instr, addr, incr_addr}
  localparam int ENTRY_W   = 3 * XLEN;
  localparam int INSTR_LSB = 2 * XLEN;
  localparam int ADDR_LSB  = XLEN;
  localparam int INCR_LSB  = 0;

  typedef logic [ENTRY_W-1:0] entry_t;

  function automatic entry_t pack_entry(input logic [XLEN-1:0] instr,
                                        input logic [XLEN-1:0] addr,
                                        input logic [XLEN-1:0] incr_addr);
    return {instr, addr, incr_addr};
  endfunction

endpackage

// File: rtl/instr_queue_mem.sv
// Entry storage for instr_queue: one synchronous write port and one
// asynchronous read port. The array carries no reset.
module instr_queue_mem
  import rv_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic          i_clk,
  input  logic          i_we,
  input  logic [AW-1:0] i_waddr,
  input  entry_t        i_wdata,
  input  logic [AW-1:0] i_raddr,
  output entry_t        o_rdata
);

  entry_t mem_q [DEPTH];

  always_ff @(posedge i_clk) begin
    if (i_we) begin
      mem_q[i_waddr] <= i_wdata;
    end
  end

  assign o_rdata = mem_q[i_raddr];

endmodule

// File: rtl/instr_queue.sv
// Fetch-to-decode instruction queue: circular buffer with valid/ready on both
// sides, whole-queue flush, and a NOP bubble presented while empty.
module instr_queue
  import rv_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                     i_clk,
  input  logic                     i_rst,
  input  logic                     i_in_valid,
  output logic                     o_in_ready,
  input  logic [31:0]              i_instr,
  input  logic [31:0]              i_instr_addr,
  input  logic [31:0]              i_incr_instr_addr,
  input  logic                     i_flush,
  output logic                     o_valid,
  input  logic                     i_ready,
  output logic [31:0]              o_instr,
  output logic [31:0]              o_instr_addr,
  output logic [31:0]              o_incr_instr_addr,
  output logic [$clog2(DEPTH):0]   o_count
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q, count_d;

  logic   full;
  logic   empty;
  logic   push;
  logic   pop;
  logic   mem_we;
  entry_t wr_entry;
  entry_t rd_entry;

  // Handshake depends only on registered occupancy; no full pass-through.
  assign full       = (count_q == CW'(DEPTH));
  assign empty      = (count_q == '0);
  assign o_in_ready = ~full;
  assign o_valid    = ~empty;
  assign o_count    = count_q;

  assign push     = i_in_valid & o_in_ready;
  assign pop      = o_valid & i_ready;
  assign mem_we   = push & ~i_flush;
  assign wr_entry = pack_entry(i_instr, i_instr_addr, i_incr_instr_addr);

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (i_flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (push) begin
        wr_ptr_d = wr_ptr_q + AW'(1);
      end
      if (pop) begin
        rd_ptr_d = rd_ptr_q + AW'(1);
      end
      case ({push, pop})
        2'b10:   count_d = count_q + CW'(1);
        2'b01:   count_d = count_q - CW'(1);
        default: count_d = count_q;
      endcase
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  instr_queue_mem #(
    .DEPTH (DEPTH),
    .AW    (AW)
  ) u_mem (
    .i_clk   (i_clk),
    .i_we    (mem_we),
    .i_waddr (wr_ptr_q),
    .i_wdata (wr_entry),
    .i_raddr (rd_ptr_q),
    .o_rdata (rd_entry)
  );

  // Stale storage must never leak to decode while empty.
  always_comb begin
    o_instr           = NOP_INSTR;
    o_instr_addr      = '0;
    o_incr_instr_addr = '0;
    if (o_valid) begin
      o_instr           = rd_entry[INSTR_LSB +: XLEN];
      o_instr_addr      = rd_entry[ADDR_LSB  +: XLEN];
      o_incr_instr_addr = rd_entry[INCR_LSB  +: XLEN];
    end
  end

endmodule

// File: tb/tb_instr_queue.sv
// Directed bench for instr_queue: a reference queue holds accepted fetches and
// each decode pop is compared against its front entry.
module tb_instr_queue;

  localparam int DEPTH = 4;

  logic        clk = 1'b0;
  logic        i_rst = 1'b1;
  logic        i_in_valid = 1'b0;
  logic        o_in_ready;
  logic [31:0] i_instr = '0;
  logic [31:0] i_instr_addr = '0;
  logic [31:0] i_incr_instr_addr = '0;
  logic        i_flush = 1'b0;
  logic        o_valid;
  logic        i_ready = 1'b0;
  logic [31:0] o_instr;
  logic [31:0] o_instr_addr;
  logic [31:0] o_incr_instr_addr;
  logic [2:0]  o_count;

  typedef struct {
    logic [31:0] instr;
    logic [31:0] addr;
    logic [31:0] incr;
  } ent_t;

  ent_t        mq[$];
  logic [31:0] got[$];
  int          vectors = 0;
  int          errors  = 0;

  always #5 clk = ~clk;

  instr_queue #(.DEPTH(DEPTH)) dut (
    .i_clk             (clk),
    .i_rst             (i_rst),
    .i_in_valid        (i_in_valid),
    .o_in_ready        (o_in_ready),
    .i_instr           (i_instr),
    .i_instr_addr      (i_instr_addr),
    .i_incr_instr_addr (i_incr_instr_addr),
    .i_flush           (i_flush),
    .o_valid           (o_valid),
    .i_ready           (i_ready),
    .o_instr           (o_instr),
    .o_instr_addr      (o_instr_addr),
    .o_incr_instr_addr (o_incr_instr_addr),
    .o_count           (o_count)
  );

  function automatic logic [31:0] mk_instr(input logic [31:0] addr);
    return {addr[15:0], 16'h0} ^ 32'hA5A5_0033;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic drive(input logic valid, input logic [31:0] addr);
    i_in_valid        = valid;
    i_instr           = mk_instr(addr);
    i_instr_addr      = addr;
    i_incr_instr_addr = addr + 32'd4;
  endtask

  // Compare all outputs against the reference queue state.
  task automatic check_state(input string tag);
    chk({tag, "_count"}, 32'(o_count), 32'(mq.size()));
    chk({tag, "_valid"}, 32'(o_valid), 32'(mq.size() != 0));
    chk({tag, "_in_ready"}, 32'(o_in_ready), 32'(mq.size() != DEPTH));
    if (mq.size() != 0) begin
      chk({tag, "_instr"}, o_instr, mq[0].instr);
      chk({tag, "_addr"},  o_instr_addr, mq[0].addr);
      chk({tag, "_incr"},  o_incr_instr_addr, mq[0].incr);
    end else begin
      chk({tag, "_nop"},   o_instr, 32'h0000_0013);
      chk({tag, "_addr0"}, o_instr_addr, 32'h0);
      chk({tag, "_incr0"}, o_incr_instr_addr, 32'h0);
    end
  endtask

  // Advance one clock: resolve handshakes from current inputs, then update the model.
  task automatic tick();
    bit   mpush;
    bit   mpop;
    ent_t e;
    ent_t h;
    mpop  = (mq.size() != 0) && i_ready;
    mpush = i_in_valid && (mq.size() < DEPTH);
    e.instr = i_instr;
    e.addr  = i_instr_addr;
    e.incr  = i_incr_instr_addr;
    if (mpop) begin
      h = mq.pop_front();
      chk("pop_instr", o_instr, h.instr);
      chk("pop_addr", o_instr_addr, h.addr);
      got.push_back(o_instr_addr);
    end
    @(posedge clk);
    if (i_rst || i_flush) begin
      mq.delete();
    end else if (mpush) begin
      mq.push_back(e);
    end
    #1;
  endtask

  initial begin
    // Reset then idle
    i_rst = 1'b1;
    drive(1'b0, 32'h0);
    tick();
    tick();
    i_rst = 1'b0;
    chk("rst_valid", 32'(o_valid), 32'h0);
    chk("rst_in_ready", 32'(o_in_ready), 32'h1);
    chk("rst_count", 32'(o_count), 32'h0);
    chk("rst_instr", o_instr, 32'h0000_0013);
    chk("rst_addr", o_instr_addr, 32'h0);
    chk("rst_incr", o_incr_instr_addr, 32'h0);
    i_ready = 1'b1;
    tick();
    check_state("idle");

    // Fill to full with decode stalled
    i_ready = 1'b0;
    for (int k = 0; k < 4; k++) begin
      drive(1'b1, 32'(4 * k));
      tick();
      check_state("fill");
    end
    chk("full_count", 32'(o_count), 32'd4);
    chk("full_in_ready", 32'(o_in_ready), 32'h0);
    drive(1'b1, 32'h10);
    for (int k = 0; k < 3; k++) begin
      tick();
      check_state("held");
      chk("held_count", 32'(o_count), 32'd4);
    end
    chk("held_head_instr", o_instr, mk_instr(32'h0));
    chk("held_head_addr", o_instr_addr, 32'h0);
    chk("held_head_incr", o_incr_instr_addr, 32'h4);

    // Drain
    drive(1'b0, 32'h0);
    i_ready = 1'b1;
    got.delete();
    for (int k = 0; k < 4; k++) begin
      tick();
      check_state("drain");
    end
    chk("drain_n", 32'(got.size()), 32'd4);
    for (int k = 0; k < 4 && k < got.size(); k++) chk("drain_order", got[k], 32'(4 * k));

    // Streaming across pointer wrap
    got.delete();
    i_ready = 1'b1;
    for (int k = 0; k < 10; k++) begin
      drive(1'b1, 32'h100 + 32'(4 * k));
      tick();
      check_state("stream");
      chk("stream_count", 32'(o_count), 32'd1);
    end
    drive(1'b0, 32'h0);
    tick();
    check_state("stream_end");
    chk("stream_n", 32'(got.size()), 32'd10);
    for (int k = 0; k < 10 && k < got.size(); k++) chk("stream_order", got[k], 32'h100 + 32'(4 * k));

    // Simultaneous push and pop while full
    i_ready = 1'b0;
    for (int k = 0; k < 4; k++) begin
      drive(1'b1, 32'h400 + 32'(4 * k));
      tick();
    end
    check_state("full2");
    drive(1'b1, 32'h410);
    i_ready = 1'b1;
    tick();
    check_state("full_pp");
    chk("full_pp_count", 32'(o_count), 32'd3);
    chk("full_pp_head", o_instr_addr, 32'h404);

    // Flush with concurrent push
    i_ready = 1'b0;
    i_flush = 1'b1;
    drive(1'b1, 32'h200);
    tick();
    i_flush = 1'b0;
    drive(1'b0, 32'h0);
    check_state("flush");
    chk("flush_count", 32'(o_count), 32'd0);
    chk("flush_valid", 32'(o_valid), 32'h0);
    chk("flush_in_ready", 32'(o_in_ready), 32'h1);
    chk("flush_nop", o_instr, 32'h0000_0013);
    drive(1'b1, 32'h300);
    tick();
    drive(1'b0, 32'h0);
    check_state("post_flush");
    chk("post_flush_valid", 32'(o_valid), 32'h1);
    chk("post_flush_addr", o_instr_addr, 32'h300);

    // Reset mid-operation
    drive(1'b1, 32'h304);
    tick();
    check_state("pre_rst");
    chk("pre_rst_count", 32'(o_count), 32'd2);
    i_rst = 1'b1;
    drive(1'b1, 32'h500);
    tick();
    i_rst = 1'b0;
    chk("mrst_valid", 32'(o_valid), 32'h0);
    chk("mrst_in_ready", 32'(o_in_ready), 32'h1);
    chk("mrst_count", 32'(o_count), 32'h0);
    chk("mrst_instr", o_instr, 32'h0000_0013);
    chk("mrst_addr", o_instr_addr, 32'h0);
    chk("mrst_incr", o_incr_instr_addr, 32'h0);
    drive(1'b1, 32'h600);
    tick();
    check_state("after_rst1");
    chk("after_rst_head", o_instr_addr, 32'h600);
    drive(1'b1, 32'h604);
    tick();
    drive(1'b0, 32'h0);
    i_ready = 1'b1;
    got.delete();
    tick();
    check_state("after_rst_pop1");
    tick();
    check_state("after_rst_pop2");
    chk("after_rst_n", 32'(got.size()), 32'd2);
    for (int k = 0; k < 2 && k < got.size(); k++) chk("after_rst_order", got[k], 32'h600 + 32'(4 * k));

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule
